cruce_semaforo_ctrl: RTL and testbench

- Intersection controller that sequences two opposing traffic-light heads (street A, street B) and a pedestrian crossing.
- Timing comes from an internal tick prescaler.
- Supports an out-of-service blink mode controlled by on_off.
- Sits above the per-head light decode. Outputs use the team's 3-bit light encoding: bit2 green, bit1 amber, bit0 red.

---
 rtl/semaforo_pkg.sv | 23 ++
 rtl/cruce_semaforo_ctrl_tick_prescaler.sv | 26 ++
 rtl/cruce_semaforo_ctrl.sv | 132 +++++++++++++
 tb/tb_cruce_semaforo_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared state encoding and 3-bit light codes {verde, amarillo, rojo} for the
// intersection controller.
package semaforo_pkg;

  typedef enum logic [3:0] {
    ROJO_AB2   = 4'd0,
    A_VERDE    = 4'd1,
    A_AMARILLO = 4'd2,
    ROJO_AB1   = 4'd3,
    B_VERDE    = 4'd4,
    B_AMARILLO = 4'd5,
    PEATON     = 4'd6,
    BLINK_OFF  = 4'd7,
    BLINK_ON   = 4'd8
  } state_t;

  localparam logic [2:0] LUZ_VERDE    = 3'b100;
  localparam logic [2:0] LUZ_AMARILLO = 3'b010;
  localparam logic [2:0] LUZ_ROJO     = 3'b001;
  localparam logic [2:0] LUZ_OFF      = 3'b000;
  localparam logic [2:0] LUZ_ALL      = 3'b111;

endpackage

// File: rtl/cruce_semaforo_ctrl_tick_prescaler.sv
// Free-running tick prescaler: one-cycle tick every TICK_DIV clocks, restartable
// via clr so every phase begins with a full tick period.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             r_cnt <= '0;
    else if (clr)           r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/cruce_semaforo_ctrl.sv
// Two-head intersection controller with pedestrian phase and out-of-service blink.
// FSM, phase counter and pedestrian latch live here; timing base is tick_prescaler.
module cruce_semaforo_ctrl #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned T_VERDE    = 10,
  parameter int unsigned T_AMARILLO = 3,
  parameter int unsigned T_ROJO     = 1,
  parameter int unsigned T_PEATON   = 8,
  parameter int unsigned T_BLINK    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_off,
  input  logic       ped_req,
  output logic [2:0] luz_a,
  output logic [2:0] luz_b,
  output logic       ped_walk,
  output logic       ped_ack
);

  import semaforo_pkg::*;

  localparam logic [7:0] L_VERDE    = 8'(T_VERDE);
  localparam logic [7:0] L_AMARILLO = 8'(T_AMARILLO);
  localparam logic [7:0] L_ROJO     = 8'(T_ROJO);
  localparam logic [7:0] L_PEATON   = 8'(T_PEATON);
  localparam logic [7:0] L_BLINK    = 8'(T_BLINK);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_phase;
  logic [7:0] w_dur;
  logic       r_pending;
  logic       r_ack;
  logic       w_tick;
  logic       w_clr;
  logic       w_done;
  logic       w_blink;
  logic       w_service;
  logic       w_serve_ped;

  assign w_clr       = (w_next != r_state);
  assign w_blink     = (r_state == BLINK_OFF) || (r_state == BLINK_ON);
  assign w_service   = r_state inside {ROJO_AB2, A_VERDE, A_AMARILLO, ROJO_AB1,
                                       B_VERDE, B_AMARILLO, PEATON};
  assign w_serve_ped = (r_state == ROJO_AB2) && (w_next == PEATON);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ROJO_AB2;
    else        r_state <= w_next;
  end

  always_comb begin
    w_dur = L_ROJO;
    case (r_state)
      A_VERDE, B_VERDE:       w_dur = L_VERDE;
      A_AMARILLO, B_AMARILLO: w_dur = L_AMARILLO;
      PEATON:                 w_dur = L_PEATON;
      BLINK_OFF, BLINK_ON:    w_dur = L_BLINK;
      default:                w_dur = L_ROJO;
    endcase
  end

  assign w_done = w_tick && (r_phase == (w_dur - 8'd1));

  // on_off overrides take precedence over phase expiry; invalid codes fall into BLINK_ON
  always_comb begin
    w_next = r_state;
    case (r_state)
      ROJO_AB2:   if (w_done) w_next = r_pending ? PEATON : A_VERDE;
      A_VERDE:    if (w_done) w_next = A_AMARILLO;
      A_AMARILLO: if (w_done) w_next = ROJO_AB1;
      ROJO_AB1:   if (w_done) w_next = B_VERDE;
      B_VERDE:    if (w_done) w_next = B_AMARILLO;
      B_AMARILLO: if (w_done) w_next = ROJO_AB2;
      PEATON:     if (w_done) w_next = A_VERDE;
      BLINK_OFF:  if (w_done) w_next = BLINK_ON;
      BLINK_ON:   if (w_done) w_next = BLINK_OFF;
      default:    w_next = BLINK_ON;
    endcase
    if (w_service && !on_off) w_next = BLINK_OFF;
    if (w_blink && on_off)    w_next = ROJO_AB2;
  end

  always_comb begin
    luz_a    = LUZ_ALL;
    luz_b    = LUZ_ALL;
    ped_walk = 1'b0;
    case (r_state)
      A_VERDE:            begin luz_a = LUZ_VERDE;    luz_b = LUZ_ROJO;     end
      A_AMARILLO:         begin luz_a = LUZ_AMARILLO; luz_b = LUZ_ROJO;     end
      ROJO_AB1, ROJO_AB2: begin luz_a = LUZ_ROJO;     luz_b = LUZ_ROJO;     end
      B_VERDE:            begin luz_a = LUZ_ROJO;     luz_b = LUZ_VERDE;    end
      B_AMARILLO:         begin luz_a = LUZ_ROJO;     luz_b = LUZ_AMARILLO; end
      PEATON:             begin luz_a = LUZ_ROJO;     luz_b = LUZ_ROJO; ped_walk = 1'b1; end
      BLINK_OFF:          begin luz_a = LUZ_OFF;      luz_b = LUZ_OFF;      end
      BLINK_ON:           begin luz_a = LUZ_ALL;      luz_b = LUZ_ALL;      end
      default:            begin luz_a = LUZ_ALL;      luz_b = LUZ_ALL;      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_phase <= '0;
    else if (w_clr)  r_phase <= '0;
    else if (w_tick) r_phase <= r_phase + 8'd1;
  end

  // Serving the request clears the latch even if ped_req is still high this cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= w_serve_ped;
      if (!on_off)          r_pending <= 1'b0;
      else if (w_serve_ped) r_pending <= 1'b0;
      else if (ped_req)     r_pending <= 1'b1;
    end
  end

  assign ped_ack = r_ack;

endmodule

// File: tb/tb_cruce_semaforo_ctrl.sv
// Directed bench for cruce_semaforo_ctrl with short timing (TICK_DIV=4, T_VERDE=3,
// T_AMARILLO=2, T_ROJO=1, T_PEATON=2, T_BLINK=1): phases of 12/8/4/8/4 cycles.
module tb_cruce_semaforo_ctrl;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] O = 3'b000;
  localparam logic [2:0] W = 3'b111;

  typedef struct packed {
    logic       oo;
    logic       rq;
    logic [2:0] a;
    logic [2:0] b;
    logic       walk;
    logic       ack;
    logic [7:0] len;
  } seg_t;

  logic       clk;
  logic       reset;
  logic       on_off;
  logic       ped_req;
  logic [2:0] luz_a;
  logic [2:0] luz_b;
  logic       ped_walk;
  logic       ped_ack;

  int total  = 0;
  int passed = 0;

  cruce_semaforo_ctrl #(
    .TICK_DIV   (4),
    .T_VERDE    (3),
    .T_AMARILLO (2),
    .T_ROJO     (1),
    .T_PEATON   (2),
    .T_BLINK    (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .on_off   (on_off),
    .ped_req  (ped_req),
    .luz_a    (luz_a),
    .luz_b    (luz_b),
    .ped_walk (ped_walk),
    .ped_ack  (ped_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic seg_t mk(input logic oo, input logic rq, input logic [2:0] a,
                              input logic [2:0] b, input logic walk, input logic ack,
                              input int len);
    seg_t s;
    s.oo = oo; s.rq = rq; s.a = a; s.b = b; s.walk = walk; s.ack = ack; s.len = 8'(len);
    return s;
  endfunction

  // Reset pulse, released on a negedge: that negedge is ROJO_AB2 cycle 0.
  task automatic do_reset();
    reset = 1'b0; on_off = 1'b1; ped_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; on_off = 1'b1; ped_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (luz_a !== R) $display("FAIL reset_luz_a: got %b want %b", luz_a, R); else passed++;
    total++; if (luz_b !== R) $display("FAIL reset_luz_b: got %b want %b", luz_b, R); else passed++;
    total++; if (ped_walk !== 1'b0) $display("FAIL reset_walk: got %b want 0", ped_walk); else passed++;
    total++; if (ped_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", ped_ack); else passed++;
    reset = 1'b1;
  endtask

  task automatic test_normal_cycle();
    seg_t q[$];
    do_reset();
    q = '{mk(1,0,R,R,0,0,4), mk(1,0,G,R,0,0,12), mk(1,0,Y,R,0,0,8), mk(1,0,R,R,0,0,4),
          mk(1,0,R,G,0,0,12), mk(1,0,R,Y,0,0,8), mk(1,0,R,R,0,0,4), mk(1,0,G,R,0,0,12),
          mk(1,0,Y,R,0,0,1)};
    for (int s = 0; s < q.size(); s++)
      for (int c = 0; c < int'(q[s].len); c++) begin
        on_off = q[s].oo; ped_req = q[s].rq;
        total++;
        if ({luz_a, luz_b, ped_walk, ped_ack} !== {q[s].a, q[s].b, q[s].walk, q[s].ack})
          $display("FAIL normal seg%0d cyc%0d: got a=%b b=%b walk=%b ack=%b want a=%b b=%b walk=%b ack=%b",
                   s, c, luz_a, luz_b, ped_walk, ped_ack, q[s].a, q[s].b, q[s].walk, q[s].ack);
        else passed++;
        @(negedge clk);
      end
  endtask

  task automatic test_ped_request();
    seg_t q[$];
    do_reset();
    q = '{mk(1,0,R,R,0,0,4), mk(1,0,G,R,0,0,12), mk(1,0,Y,R,0,0,8), mk(1,0,R,R,0,0,4),
          mk(1,1,R,G,0,0,1), mk(1,0,R,G,0,0,11), mk(1,0,R,Y,0,0,8), mk(1,0,R,R,0,0,4),
          mk(1,0,R,R,1,1,1), mk(1,0,R,R,1,0,7),
          mk(1,0,G,R,0,0,12), mk(1,0,Y,R,0,0,8), mk(1,0,R,R,0,0,4), mk(1,0,R,G,0,0,12),
          mk(1,0,R,Y,0,0,8), mk(1,0,R,R,0,0,4), mk(1,0,G,R,0,0,2)};
    for (int s = 0; s < q.size(); s++)
      for (int c = 0; c < int'(q[s].len); c++) begin
        on_off = q[s].oo; ped_req = q[s].rq;
        total++;
        if ({luz_a, luz_b, ped_walk, ped_ack} !== {q[s].a, q[s].b, q[s].walk, q[s].ack})
          $display("FAIL ped seg%0d cyc%0d: got a=%b b=%b walk=%b ack=%b want a=%b b=%b walk=%b ack=%b",
                   s, c, luz_a, luz_b, ped_walk, ped_ack, q[s].a, q[s].b, q[s].walk, q[s].ack);
        else passed++;
        @(negedge clk);
      end
  endtask

  // Request latched early in A_VERDE must be dropped by the blink entry.
  task automatic test_blink();
    seg_t q[$];
    do_reset();
    q = '{mk(1,0,R,R,0,0,4), mk(1,1,G,R,0,0,2), mk(1,0,G,R,0,0,3), mk(0,0,G,R,0,0,1),
          mk(0,1,O,O,0,0,4), mk(0,1,W,W,0,0,4), mk(0,1,O,O,0,0,4), mk(0,1,W,W,0,0,2)};
    for (int s = 0; s < q.size(); s++)
      for (int c = 0; c < int'(q[s].len); c++) begin
        on_off = q[s].oo; ped_req = q[s].rq;
        total++;
        if ({luz_a, luz_b, ped_walk, ped_ack} !== {q[s].a, q[s].b, q[s].walk, q[s].ack})
          $display("FAIL blink seg%0d cyc%0d: got a=%b b=%b walk=%b ack=%b want a=%b b=%b walk=%b ack=%b",
                   s, c, luz_a, luz_b, ped_walk, ped_ack, q[s].a, q[s].b, q[s].walk, q[s].ack);
        else passed++;
        @(negedge clk);
      end
  endtask

  task automatic test_return_to_service();
    seg_t q[$];
    q = '{mk(1,0,W,W,0,0,1), mk(1,0,R,R,0,0,4), mk(1,0,G,R,0,0,12), mk(1,0,Y,R,0,0,1)};
    for (int s = 0; s < q.size(); s++)
      for (int c = 0; c < int'(q[s].len); c++) begin
        on_off = q[s].oo; ped_req = q[s].rq;
        total++;
        if ({luz_a, luz_b, ped_walk, ped_ack} !== {q[s].a, q[s].b, q[s].walk, q[s].ack})
          $display("FAIL resume seg%0d cyc%0d: got a=%b b=%b walk=%b ack=%b want a=%b b=%b walk=%b ack=%b",
                   s, c, luz_a, luz_b, ped_walk, ped_ack, q[s].a, q[s].b, q[s].walk, q[s].ack);
        else passed++;
        @(negedge clk);
      end
  endtask

  task automatic test_async_reset();
    seg_t q[$];
    do_reset();
    q = '{mk(1,0,R,R,0,0,4), mk(1,0,G,R,0,0,12), mk(1,0,Y,R,0,0,8), mk(1,0,R,R,0,0,4),
          mk(1,0,R,G,0,0,12), mk(1,0,R,Y,0,0,3)};
    for (int s = 0; s < q.size(); s++)
      for (int c = 0; c < int'(q[s].len); c++) begin
        on_off = q[s].oo; ped_req = q[s].rq;
        total++;
        if ({luz_a, luz_b, ped_walk, ped_ack} !== {q[s].a, q[s].b, q[s].walk, q[s].ack})
          $display("FAIL arst_pre seg%0d cyc%0d: got a=%b b=%b walk=%b ack=%b want a=%b b=%b walk=%b ack=%b",
                   s, c, luz_a, luz_b, ped_walk, ped_ack, q[s].a, q[s].b, q[s].walk, q[s].ack);
        else passed++;
        @(negedge clk);
      end
    total++; if (luz_b !== Y) $display("FAIL arst_mid_amber: got b=%b want %b", luz_b, Y); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if ({luz_a, luz_b} !== {R, R})
      $display("FAIL arst_immediate: got a=%b b=%b want a=%b b=%b", luz_a, luz_b, R, R); else passed++;
    @(negedge clk);
    reset = 1'b1;
    q = '{mk(1,0,R,R,0,0,4), mk(1,0,G,R,0,0,2)};
    for (int s = 0; s < q.size(); s++)
      for (int c = 0; c < int'(q[s].len); c++) begin
        on_off = q[s].oo; ped_req = q[s].rq;
        total++;
        if ({luz_a, luz_b, ped_walk, ped_ack} !== {q[s].a, q[s].b, q[s].walk, q[s].ack})
          $display("FAIL arst_post seg%0d cyc%0d: got a=%b b=%b walk=%b ack=%b want a=%b b=%b walk=%b ack=%b",
                   s, c, luz_a, luz_b, ped_walk, ped_ack, q[s].a, q[s].b, q[s].walk, q[s].ack);
        else passed++;
        @(negedge clk);
      end
  endtask

  // ped_req high through the whole ROJO_AB2 and the first PEATON cycle.
  task automatic test_back_to_back_ped();
    seg_t q[$];
    do_reset();
    q = '{mk(1,0,R,R,0,0,4), mk(1,0,G,R,0,0,12), mk(1,0,Y,R,0,0,8), mk(1,0,R,R,0,0,4),
          mk(1,0,R,G,0,0,12), mk(1,0,R,Y,0,0,8), mk(1,1,R,R,0,0,4),
          mk(1,1,R,R,1,1,1), mk(1,0,R,R,1,0,7),
          mk(1,0,G,R,0,0,12), mk(1,0,Y,R,0,0,8), mk(1,0,R,R,0,0,4), mk(1,0,R,G,0,0,12),
          mk(1,0,R,Y,0,0,8), mk(1,0,R,R,0,0,4),
          mk(1,0,R,R,1,1,1), mk(1,0,R,R,1,0,7), mk(1,0,G,R,0,0,1)};
    for (int s = 0; s < q.size(); s++)
      for (int c = 0; c < int'(q[s].len); c++) begin
        on_off = q[s].oo; ped_req = q[s].rq;
        total++;
        if ({luz_a, luz_b, ped_walk, ped_ack} !== {q[s].a, q[s].b, q[s].walk, q[s].ack})
          $display("FAIL b2b seg%0d cyc%0d: got a=%b b=%b walk=%b ack=%b want a=%b b=%b walk=%b ack=%b",
                   s, c, luz_a, luz_b, ped_walk, ped_ack, q[s].a, q[s].b, q[s].walk, q[s].ack);
        else passed++;
        @(negedge clk);
      end
  endtask

  initial begin
    reset = 1'b0; on_off = 1'b1; ped_req = 1'b0;
    test_reset();
    test_normal_cycle();
    test_ped_request();
    test_blink();
    test_return_to_service();
    test_async_reset();
    test_back_to_back_ped();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget (%0d/%0d so far)", passed, total);
    $fatal(1);
  end

endmodule
